round_ctl: RTL and testbench

- Turn sequencer for the two-player sum game.
- Gates player load pulses into the p1/p2 load registers and samples the checker's sum_status after the adder settles.
- Keeps per-player scores and the round count, and declares a winner.
- Sits between the button shapers / access controller and the loadreg pair. Runs only while access is granted.

---
 rtl/round_ctl_pkg.sv | 33 +++
 rtl/round_ctl_turn_timer.sv | 35 +++
 rtl/round_ctl.sv | 220 ++++++++++++++++++++++
 tb/tb_round_ctl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/round_ctl_pkg.sv
// round_ctl_pkg: definitions shared by round_ctl and turn_timer.
//   - state_t   : sequencer states, 3-bit encoding
//   - ST_*      : sum_status codes from the checker
//   - TURN_*    : one-hot codes used for both turn and winner
//   - turn_of() : the player who is active in a given state
package round_ctl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_P1   = 3'd1,
    S_WAIT_P2   = 3'd2,
    S_SETTLE    = 3'd3,
    S_EVAL      = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam logic [1:0] ST_UNDER = 2'b00;
  localparam logic [1:0] ST_HIT   = 2'b01;
  localparam logic [1:0] ST_OVER  = 2'b10;

  localparam logic [1:0] TURN_NONE = 2'b00;
  localparam logic [1:0] TURN_P1   = 2'b01;
  localparam logic [1:0] TURN_P2   = 2'b10;

  function automatic logic [1:0] turn_of(input state_t s);
    logic [1:0] t;
    t = TURN_NONE;
    if (s == S_WAIT_P1) t = TURN_P1;
    if (s == S_WAIT_P2) t = TURN_P2;
    return t;
  endfunction

endpackage

// File: rtl/round_ctl_turn_timer.sv
// turn_timer: idle timer for the active player's turn.
//   CLOCK    in  system clock
//   RESET    in  synchronous, active-high reset
//   i_clear  in  force the count to zero (wins over i_enable)
//   i_enable in  count this cycle (low while play is paused)
//   o_expire out high on the enabled cycle whose count is TIMEOUT_CYC-1
module turn_timer #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned TW          = 26
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [TW-1:0] TC = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Only an enabled cycle can expire, so a paused turn never times out.
  assign o_expire = i_enable && (r_count == TC);

endmodule

// File: rtl/round_ctl.sv
// round_ctl: turn sequencer for the two-player sum game.
// Gates player presses into load pulses, samples the checker result,
// keeps scores and the round count, and declares a winner.
//   CLOCK       in  system clock
//   RESET       in  synchronous, active-high reset
//   unlocked    in  play granted by the access controller (level)
//   p1_bpress   in  shaped press, player 1 (one cycle)
//   p2_bpress   in  shaped press, player 2 (one cycle)
//   sum_status  in  checker result (00 under, 01 hit, 10 over, 11 as under)
//   p1_load     out load enable to the p1 load register (one cycle)
//   p2_load     out load enable to the p2 load register (one cycle)
//   turn        out active player, one-hot (00 none)
//   p1_score    out player 1 points
//   p2_score    out player 2 points
//   round_num   out completed rounds, saturating at 15
//   winner      out 00 none, 01 P1, 10 P2
//   game_over   out high while in GAME_OVER
//   timeout_evt out pulse when a turn times out
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for the first grant after reset
// WAIT_P1   | player 1 to press; idle timer running
// WAIT_P2   | player 2 to press; idle timer running
// SETTLE    | load register captures, adder/checker settle
// EVAL      | sum_status sampled, round scored, win check
// GAME_OVER | results held until a granted player 1 press
module round_ctl
  import round_ctl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned WIN_SCORE   = 3,
  parameter int unsigned TW          = 26
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       unlocked,
  input  logic       p1_bpress,
  input  logic       p2_bpress,
  input  logic [1:0] sum_status,
  output logic       p1_load,
  output logic       p2_load,
  output logic [1:0] turn,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] round_num,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       timeout_evt
);

  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

  state_t     r_state, w_state_nxt;
  logic       r_p1_load, r_p2_load, r_tmo;
  logic [1:0] r_turn, r_winner;
  logic [3:0] r_p1_score, r_p2_score, r_round;
  logic       r_game_over;

  logic       w_p1_load_nxt, w_p2_load_nxt, w_tmo_nxt;
  logic [1:0] w_turn_nxt, w_winner_nxt;
  logic [3:0] w_p1_score_nxt, w_p2_score_nxt, w_round_nxt, w_round_inc;
  logic       w_tmr_clear, w_tmr_en, w_expire;

  turn_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TW         (TW)
  ) u_timer (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .i_clear (w_tmr_clear),
    .i_enable(w_tmr_en),
    .o_expire(w_expire)
  );

  assign w_round_inc = (r_round == 4'd15) ? 4'd15 : r_round + 4'd1;

  always_ff @(posedge CLOCK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_p1_load_nxt  = 1'b0;
    w_p2_load_nxt  = 1'b0;
    w_tmo_nxt      = 1'b0;
    w_p1_score_nxt = r_p1_score;
    w_p2_score_nxt = r_p2_score;
    w_round_nxt    = r_round;
    w_winner_nxt   = r_winner;
    w_tmr_clear    = 1'b1;
    w_tmr_en       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (unlocked) w_state_nxt = S_WAIT_P1;
      end

      S_WAIT_P1: begin
        w_tmr_clear = 1'b0;
        w_tmr_en    = unlocked;
        // A press on the expiring cycle wins over the timeout.
        if (unlocked && p1_bpress) begin
          w_p1_load_nxt = 1'b1;
          w_tmr_clear   = 1'b1;
          w_state_nxt   = S_WAIT_P2;
        end else if (w_expire) begin
          w_tmo_nxt      = 1'b1;
          w_tmr_clear    = 1'b1;
          w_p2_score_nxt = r_p2_score + 4'd1;
          w_round_nxt    = w_round_inc;
          if (w_p2_score_nxt == WIN4) begin
            w_winner_nxt = TURN_P2;
            w_state_nxt  = S_GAME_OVER;
          end else begin
            w_state_nxt  = S_WAIT_P1;
          end
        end
      end

      S_WAIT_P2: begin
        w_tmr_clear = 1'b0;
        w_tmr_en    = unlocked;
        if (unlocked && p2_bpress) begin
          w_p2_load_nxt = 1'b1;
          w_tmr_clear   = 1'b1;
          w_state_nxt   = S_SETTLE;
        end else if (w_expire) begin
          w_tmo_nxt      = 1'b1;
          w_tmr_clear    = 1'b1;
          w_p1_score_nxt = r_p1_score + 4'd1;
          w_round_nxt    = w_round_inc;
          if (w_p1_score_nxt == WIN4) begin
            w_winner_nxt = TURN_P1;
            w_state_nxt  = S_GAME_OVER;
          end else begin
            w_state_nxt  = S_WAIT_P1;
          end
        end
      end

      S_SETTLE: begin
        if (unlocked) w_state_nxt = S_EVAL;
      end

      // Completes even if the grant drops; the result is already latched.
      S_EVAL: begin
        w_round_nxt = w_round_inc;
        if (sum_status == ST_HIT) begin
          w_p2_score_nxt = r_p2_score + 4'd1;
          if (w_p2_score_nxt == WIN4) begin
            w_winner_nxt = TURN_P2;
            w_state_nxt  = S_GAME_OVER;
          end else begin
            w_state_nxt  = S_WAIT_P1;
          end
        end else begin
          w_p1_score_nxt = r_p1_score + 4'd1;
          if (w_p1_score_nxt == WIN4) begin
            w_winner_nxt = TURN_P1;
            w_state_nxt  = S_GAME_OVER;
          end else begin
            w_state_nxt  = S_WAIT_P1;
          end
        end
      end

      S_GAME_OVER: begin
        if (unlocked && p1_bpress) begin
          w_p1_score_nxt = 4'd0;
          w_p2_score_nxt = 4'd0;
          w_round_nxt    = 4'd0;
          w_winner_nxt   = TURN_NONE;
          w_state_nxt    = S_WAIT_P1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Turn is blanked whenever the grant was absent at this edge.
    w_turn_nxt = unlocked ? turn_of(w_state_nxt) : TURN_NONE;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_p1_load   <= 1'b0;
      r_p2_load   <= 1'b0;
      r_tmo       <= 1'b0;
      r_turn      <= TURN_NONE;
      r_p1_score  <= 4'd0;
      r_p2_score  <= 4'd0;
      r_round     <= 4'd0;
      r_winner    <= TURN_NONE;
      r_game_over <= 1'b0;
    end else begin
      r_p1_load   <= w_p1_load_nxt;
      r_p2_load   <= w_p2_load_nxt;
      r_tmo       <= w_tmo_nxt;
      r_turn      <= w_turn_nxt;
      r_p1_score  <= w_p1_score_nxt;
      r_p2_score  <= w_p2_score_nxt;
      r_round     <= w_round_nxt;
      r_winner    <= w_winner_nxt;
      r_game_over <= (w_state_nxt == S_GAME_OVER);
    end
  end

  assign p1_load     = r_p1_load;
  assign p2_load     = r_p2_load;
  assign timeout_evt = r_tmo;
  assign turn        = r_turn;
  assign p1_score    = r_p1_score;
  assign p2_score    = r_p2_score;
  assign round_num   = r_round;
  assign winner      = r_winner;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_round_ctl.sv
// tb_round_ctl: directed game scenarios followed by random play, every
// cycle compared against a round-level reference model of the game.
module tb_round_ctl;

  localparam int TMO = 8;
  localparam int WIN = 3;

  logic       CLOCK;
  logic       RESET;
  logic       unlocked;
  logic       p1_bpress, p2_bpress;
  logic [1:0] sum_status;
  logic       p1_load, p2_load, game_over, timeout_evt;
  logic [1:0] turn, winner;
  logic [3:0] p1_score, p2_score, round_num;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game phase, idle cycles on the current turn, tallies.
  // phase: 0 before first grant, 1 P1 to play, 2 P2 to play,
  //        3 loads settling, 4 result being read, 5 game finished
  int m_phase, m_idle, m_s1, m_s2, m_rounds, m_win;
  int e_l1, e_l2, e_tmo, e_turn;

  round_ctl #(
    .TIMEOUT_CYC(TMO),
    .WIN_SCORE  (WIN),
    .TW         (5)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .unlocked   (unlocked),
    .p1_bpress  (p1_bpress),
    .p2_bpress  (p2_bpress),
    .sum_status (sum_status),
    .p1_load    (p1_load),
    .p2_load    (p2_load),
    .turn       (turn),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .round_num  (round_num),
    .winner     (winner),
    .game_over  (game_over),
    .timeout_evt(timeout_evt)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic award(input int p);
    if (p == 1) m_s1++; else m_s2++;
    m_rounds = (m_rounds >= 15) ? 15 : m_rounds + 1;
    m_idle = 0;
    if ((p == 1 ? m_s1 : m_s2) == WIN) begin
      m_win   = p;
      m_phase = 5;
    end else begin
      m_phase = 1;
    end
  endtask

  task automatic model_step(input bit rst, input bit ul, input bit b1, input bit b2,
                            input logic [1:0] ss);
    e_l1 = 0; e_l2 = 0; e_tmo = 0;
    if (rst) begin
      m_phase = 0; m_idle = 0; m_s1 = 0; m_s2 = 0; m_rounds = 0; m_win = 0;
    end else begin
      case (m_phase)
        0: if (ul) begin m_phase = 1; m_idle = 0; end
        1, 2: if (ul) begin
          if ((m_phase == 1 && b1) || (m_phase == 2 && b2)) begin
            if (m_phase == 1) begin e_l1 = 1; m_phase = 2; end
            else begin e_l2 = 1; m_phase = 3; end
            m_idle = 0;
          end else if (m_idle == TMO - 1) begin
            e_tmo = 1;
            award(m_phase == 1 ? 2 : 1);
          end else begin
            m_idle++;
          end
        end
        3: if (ul) m_phase = 4;
        4: award(ss == 2'b01 ? 2 : 1);
        5: if (ul && b1) begin
          m_s1 = 0; m_s2 = 0; m_rounds = 0; m_win = 0; m_idle = 0; m_phase = 1;
        end
        default: m_phase = 0;
      endcase
    end
    e_turn = (!rst && ul && (m_phase == 1 || m_phase == 2)) ? m_phase : 0;
  endtask

  task automatic check_outputs();
    chk("p1_load", 32'(p1_load), 32'(e_l1));
    chk("p2_load", 32'(p2_load), 32'(e_l2));
    chk("timeout_evt", 32'(timeout_evt), 32'(e_tmo));
    chk("turn", 32'(turn), 32'(e_turn));
    chk("p1_score", 32'(p1_score), 32'(m_s1));
    chk("p2_score", 32'(p2_score), 32'(m_s2));
    chk("round_num", 32'(round_num), 32'(m_rounds));
    chk("winner", 32'(winner), 32'(m_win));
    chk("game_over", 32'(game_over), 32'(m_phase == 5));
    chk("pulse_excl", 32'($countones({p1_load, p2_load, timeout_evt}) <= 1), 32'd1);
  endtask

  // Apply inputs, clock once, then compare on the falling edge.
  task automatic cycle(input bit rst, input bit ul, input bit b1, input bit b2,
                       input logic [1:0] ss);
    RESET = rst; unlocked = ul; p1_bpress = b1; p2_bpress = b2; sum_status = ss;
    @(posedge CLOCK);
    model_step(rst, ul, b1, b2, ss);
    @(negedge CLOCK);
    check_outputs();
  endtask

  task automatic play_round(input logic [1:0] ss);
    cycle(0, 1, 1, 0, ss);
    cycle(0, 1, 0, 1, ss);
    cycle(0, 1, 0, 0, ss);
    cycle(0, 1, 0, 0, ss);
  endtask

  initial begin
    RESET = 1'b1; unlocked = 1'b0; p1_bpress = 1'b0; p2_bpress = 1'b0; sum_status = 2'b00;
    m_phase = 0; m_idle = 0; m_s1 = 0; m_s2 = 0; m_rounds = 0; m_win = 0;
    e_l1 = 0; e_l2 = 0; e_tmo = 0; e_turn = 0;
    @(negedge CLOCK);

    cycle(1, 0, 0, 0, 2'b00);
    cycle(1, 1, 1, 1, 2'b01);
    chk("rst_turn", 32'(turn), 32'd0);

    // First round: P1 loads, P2 loads, hit scores for P2.
    cycle(0, 1, 0, 0, 2'b00);
    chk("dir_turn_p1", 32'(turn), 32'd1);
    cycle(0, 1, 1, 0, 2'b00);
    chk("dir_p1_load", 32'(p1_load), 32'd1);
    chk("dir_turn_p2", 32'(turn), 32'd2);
    cycle(0, 1, 0, 0, 2'b01);
    cycle(0, 1, 0, 1, 2'b01);
    cycle(0, 1, 0, 0, 2'b01);
    cycle(0, 1, 0, 0, 2'b01);
    chk("dir_hit_p2", 32'(p2_score), 32'd1);
    chk("dir_round1", 32'(round_num), 32'd1);

    // Three overs: P1 reaches WIN.
    for (int r = 0; r < 3; r++) play_round(2'b10);
    chk("dir_win_p1", 32'(winner), 32'd1);
    chk("dir_gover", 32'(game_over), 32'd1);
    cycle(0, 1, 0, 1, 2'b01);
    cycle(0, 0, 1, 0, 2'b01);
    chk("dir_hold_p1", 32'(p1_score), 32'd3);
    cycle(0, 1, 1, 0, 2'b00);
    chk("dir_restart", 32'(p1_score), 32'd0);

    // Idle turn times out on the TMO-th cycle.
    for (int i = 0; i < TMO; i++) cycle(0, 1, 0, 0, 2'b00);
    chk("dir_tmo_p2", 32'(p2_score), 32'd1);

    // Wrong-player press, then simultaneous presses in WAIT_P2.
    cycle(0, 1, 1, 0, 2'b01);
    cycle(0, 1, 1, 0, 2'b01);
    cycle(0, 1, 1, 1, 2'b01);
    cycle(0, 1, 0, 0, 2'b01);
    cycle(0, 1, 0, 0, 2'b01);
    chk("dir_p2_two", 32'(p2_score), 32'd2);

    // Pause with five idle cycles counted; expiry three cycles after resume.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 2'b00);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1, 2'b00);
    chk("dir_pause_turn", 32'(turn), 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 2'b00);
    chk("dir_resume_tmo", 32'(timeout_evt), 32'd1);
    chk("dir_win_p2", 32'(winner), 32'd2);

    // Reset while settling with P1 on two points.
    cycle(0, 1, 1, 0, 2'b00);
    play_round(2'b00);
    play_round(2'b11);
    cycle(0, 1, 1, 0, 2'b00);
    cycle(0, 1, 0, 1, 2'b00);
    chk("dir_p1_two", 32'(p1_score), 32'd2);
    cycle(1, 1, 1, 1, 2'b01);
    chk("dir_rst_score", 32'(p1_score), 32'd0);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0,
            2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
